// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the fetch PC and issues pipelined requests to
// instruction memory. In-order returns are buffered with their PC in a
// circular prefetch queue that feeds IF/ID. A taken redirect flushes the
// queue and discards responses that are still in flight.
// Optional build macro: IFU_PERF_CNT_EN adds a saturating Fetch_Stall_Count
// output.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        LE,
  input  logic        Redirect,
  input  logic [31:0] Redirect_TA,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ready,
  input  logic        Imem_Rvalid,
  input  logic [31:0] Imem_Rdata,
  output logic [31:0] Instruction_OUT,
  output logic [31:0] PCOG_OUT,
  output logic [31:0] PC4_OUT,
  output logic        Inst_Valid
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] Fetch_Stall_Count
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // One extra bit so a count can reach FIFO_DEPTH itself.
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SumW = CntW + 1;

  localparam logic [31:0]     NopInstr     = 32'h0000_0013;
  localparam logic [PtrW-1:0] PtrOne       = PtrW'(1);
  localparam logic [CntW-1:0] CntOne       = CntW'(1);
  localparam logic [SumW-1:0] DepthCredits = SumW'(FIFO_DEPTH);

  logic [31:0]           pc_q;
  logic [31:0]           slot_pc_q    [FIFO_DEPTH];
  logic [31:0]           slot_instr_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] slot_filled_q, slot_filled_d;
  logic [PtrW-1:0]       alloc_ptr_q, fill_ptr_q, head_ptr_q;
  logic [CntW-1:0]       alloc_cnt_q, alloc_cnt_d;
  logic [CntW-1:0]       drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0]       filled_cnt, unfilled_cnt;
  logic [SumW-1:0]       credits_used;
  logic                  issue, fill, drop, pop;

  // Target alignment discards the low address bits.
  logic unused_ta_lsb;
  assign unused_ta_lsb = ^Redirect_TA[1:0];

  // Credits: every allocated slot and every stale response still owed holds one.
  assign credits_used = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};
  assign Imem_Req     = credits_used < DepthCredits;
  assign Imem_Addr    = pc_q;

  assign issue      = Imem_Req & Imem_Ready;
  assign fill       = Imem_Rvalid & (drop_cnt_q == '0);
  assign drop       = Imem_Rvalid & (drop_cnt_q != '0);
  assign Inst_Valid = slot_filled_q[head_ptr_q];
  assign pop        = LE & Inst_Valid;

  // Head slot drives IF/ID; an empty head shows a NOP bubble.
  always_comb begin
    Instruction_OUT = NopInstr;
    PCOG_OUT        = '0;
    PC4_OUT         = '0;
    if (Inst_Valid) begin
      Instruction_OUT = slot_instr_q[head_ptr_q];
      PCOG_OUT        = slot_pc_q[head_ptr_q];
      PC4_OUT         = slot_pc_q[head_ptr_q] + 32'd4;
    end
  end

  // Allocated-but-unfilled slots become stale responses on a redirect.
  always_comb begin
    filled_cnt = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      filled_cnt = filled_cnt + CntW'(slot_filled_q[i]);
    end
    unfilled_cnt = alloc_cnt_q - filled_cnt;
  end

  // Next-state for slot valid bits and the two credit counters.
  always_comb begin
    slot_filled_d = slot_filled_q;
    if (pop) slot_filled_d[head_ptr_q] = 1'b0;
    if (fill) slot_filled_d[fill_ptr_q] = 1'b1;

    alloc_cnt_d = alloc_cnt_q;
    if (issue && !pop) begin
      alloc_cnt_d = alloc_cnt_q + CntOne;
    end else if (!issue && pop) begin
      alloc_cnt_d = alloc_cnt_q - CntOne;
    end

    drop_cnt_d = drop ? (drop_cnt_q - CntOne) : drop_cnt_q;

    if (Redirect) begin
      slot_filled_d = '0;
      alloc_cnt_d   = '0;
      // A response arriving this cycle settles one owed return, fill or drop alike.
      drop_cnt_d    = drop_cnt_q + unfilled_cnt + CntW'(issue) - CntW'(Imem_Rvalid);
    end
  end

  // Control state: fetch PC, queue pointers and counters.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      pc_q          <= RESET_PC;
      slot_filled_q <= '0;
      alloc_ptr_q   <= '0;
      fill_ptr_q    <= '0;
      head_ptr_q    <= '0;
      alloc_cnt_q   <= '0;
      drop_cnt_q    <= '0;
    end else begin
      slot_filled_q <= slot_filled_d;
      alloc_cnt_q   <= alloc_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      if (Redirect) begin
        pc_q        <= {Redirect_TA[31:2], 2'b00};
        alloc_ptr_q <= '0;
        fill_ptr_q  <= '0;
        head_ptr_q  <= '0;
      end else begin
        if (issue) begin
          pc_q        <= pc_q + 32'd4;
          alloc_ptr_q <= alloc_ptr_q + PtrOne;
        end
        if (fill) fill_ptr_q <= fill_ptr_q + PtrOne;
        if (pop) head_ptr_q <= head_ptr_q + PtrOne;
      end
    end
  end

  // Slot payload; qualified by the valid bits, so no reset is needed.
  always_ff @(posedge clk) begin
    if (issue) slot_pc_q[alloc_ptr_q] <= pc_q;
    if (fill) slot_instr_q[fill_ptr_q] <= Imem_Rdata;
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  assign Fetch_Stall_Count = stall_cnt_q;

  // Count cycles where ID wants an instruction but none is ready; saturates.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      stall_cnt_q <= '0;
    end else if (LE && !Inst_Valid && !Redirect && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vectors for the documented
// corner cases plus randomized traffic against a transaction-level model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RstPc = 32'h0000_0100;
  localparam int Depth = 4;

  logic        clk = 1'b0;
  logic        Reset, LE, Redirect, Imem_Ready, Imem_Rvalid;
  logic [31:0] Redirect_TA, Imem_Rdata;
  logic        Imem_Req, Inst_Valid;
  logic [31:0] Imem_Addr, Instruction_OUT, PCOG_OUT, PC4_OUT;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] Fetch_Stall_Count;
`endif

  instruction_fetch_unit #(
    .RESET_PC  (RstPc),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk            (clk),
    .Reset          (Reset),
    .LE             (LE),
    .Redirect       (Redirect),
    .Redirect_TA    (Redirect_TA),
    .Imem_Req       (Imem_Req),
    .Imem_Addr      (Imem_Addr),
    .Imem_Ready     (Imem_Ready),
    .Imem_Rvalid    (Imem_Rvalid),
    .Imem_Rdata     (Imem_Rdata),
    .Instruction_OUT(Instruction_OUT),
    .PCOG_OUT       (PCOG_OUT),
    .PC4_OUT        (PC4_OUT),
    .Inst_Valid     (Inst_Valid)
`ifdef IFU_PERF_CNT_EN
    ,
    .Fetch_Stall_Count(Fetch_Stall_Count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: odd multiplier makes every address map to a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // In-order memory with per-request latency.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mem_q[$];
  int    cyc = 0;
  int    last_due = 0;
  int    lat_min = 1;
  int    lat_max = 1;

  // Reference model: live entries in program order plus a count of owed stale returns.
  typedef struct {
    logic [31:0] pc;
    logic        filled;
    logic [31:0] instr;
  } ent_t;
  ent_t        m_live[$];
  int          m_stale;
  logic [31:0] m_pc;
  logic [31:0] m_stall;

  logic        d_le, d_redir, d_rdy, d_rst;
  logic [31:0] d_ta;

  task automatic model_reset();
    m_live.delete();
    m_stale = 0;
    m_pc    = RstPc;
    m_stall = 32'd0;
    mem_q.delete();
    last_due = cyc;
  endtask

  // Drive one cycle's inputs, then wait to the sampling edge.
  task automatic step_begin(input logic le, input logic redir, input logic [31:0] ta,
                            input logic rdy, input logic rst);
    d_le = le; d_redir = redir; d_ta = ta; d_rdy = rdy; d_rst = rst;
    Reset = rst; LE = le; Redirect = redir; Redirect_TA = ta; Imem_Ready = rdy;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      Imem_Rvalid = 1'b1;
      Imem_Rdata  = mem_word(mem_q[0].addr);
    end else begin
      Imem_Rvalid = 1'b0;
      Imem_Rdata  = $urandom;
    end
    @(negedge clk);
  endtask

  // Compare against the model, then advance model and memory across the edge.
  task automatic step_end();
    logic        m_valid, m_req, hs_m, rv;
    logic [31:0] e_instr, e_pc, e_pc4;
    int          unf, due;
    m_valid = (m_live.size() > 0) && m_live[0].filled;
    m_req   = (m_live.size() + m_stale) < Depth;
    e_instr = m_valid ? m_live[0].instr : 32'h0000_0013;
    e_pc    = m_valid ? m_live[0].pc : 32'd0;
    e_pc4   = m_valid ? (m_live[0].pc + 32'd4) : 32'd0;
    check("imem_req", Imem_Req, m_req);
    check("imem_addr", Imem_Addr, m_pc);
    check("inst_valid", Inst_Valid, m_valid);
    check("instruction", Instruction_OUT, e_instr);
    check("pcog", PCOG_OUT, e_pc);
    check("pc4", PC4_OUT, e_pc4);
`ifdef IFU_PERF_CNT_EN
    check("stall_count", Fetch_Stall_Count, m_stall);
`endif
    rv   = Imem_Rvalid;
    hs_m = m_req & d_rdy;
    if (!d_rst) begin
      model_reset();
    end else begin
      if (rv) void'(mem_q.pop_front());
      if (Imem_Req && d_rdy) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{addr: Imem_Addr, due: due});
      end
      if (d_le && !m_valid && !d_redir && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (d_redir) begin
        unf = 0;
        foreach (m_live[i]) if (!m_live[i].filled) unf++;
        m_stale = m_stale + unf + int'(hs_m) - int'(rv);
        m_live.delete();
        m_pc = {d_ta[31:2], 2'b00};
      end else begin
        if (d_le && m_valid) void'(m_live.pop_front());
        if (rv) begin
          if (m_stale > 0) begin
            m_stale--;
          end else begin
            for (int i = 0; i < m_live.size(); i++) begin
              if (!m_live[i].filled) begin
                m_live[i].filled = 1'b1;
                m_live[i].instr  = Imem_Rdata;
                break;
              end
            end
          end
        end
        if (hs_m) begin
          m_live.push_back('{pc: m_pc, filled: 1'b0, instr: 32'd0});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cycle(input logic le, input logic redir, input logic [31:0] ta,
                       input logic rdy, input logic rst);
    step_begin(le, redir, ta, rdy, rst);
    step_end();
  endtask

  typedef struct {
    logic        le;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_pcog;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t vecs[6];

  int   n_hs;
  logic found;

  initial begin
    // Streaming from reset: 1-cycle memory, LE held high.
    vecs[0] = '{le: 1'b1, rdy: 1'b1, exp_valid: 1'b0, exp_pcog: 32'h000, exp_addr: 32'h100};
    vecs[1] = '{le: 1'b1, rdy: 1'b1, exp_valid: 1'b0, exp_pcog: 32'h000, exp_addr: 32'h104};
    vecs[2] = '{le: 1'b1, rdy: 1'b1, exp_valid: 1'b1, exp_pcog: 32'h100, exp_addr: 32'h108};
    vecs[3] = '{le: 1'b1, rdy: 1'b1, exp_valid: 1'b1, exp_pcog: 32'h104, exp_addr: 32'h10C};
    vecs[4] = '{le: 1'b1, rdy: 1'b1, exp_valid: 1'b1, exp_pcog: 32'h108, exp_addr: 32'h110};
    vecs[5] = '{le: 1'b1, rdy: 1'b1, exp_valid: 1'b1, exp_pcog: 32'h10C, exp_addr: 32'h114};

    Reset = 1'b0; LE = 1'b0; Redirect = 1'b0; Redirect_TA = '0;
    Imem_Ready = 1'b0; Imem_Rvalid = 1'b0; Imem_Rdata = '0;
    @(posedge clk);
    #1;
    model_reset();
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    lat_min = 1; lat_max = 1;
    foreach (vecs[i]) begin
      step_begin(vecs[i].le, 1'b0, 32'd0, vecs[i].rdy, 1'b1);
      check($sformatf("vec%0d_valid", i), Inst_Valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_pcog", i), PCOG_OUT, vecs[i].exp_pcog);
      check($sformatf("vec%0d_addr", i), Imem_Addr, vecs[i].exp_addr);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_pc4", i), PC4_OUT, vecs[i].exp_pcog + 32'd4);
        check($sformatf("vec%0d_instr", i), Instruction_OUT, mem_word(vecs[i].exp_pcog));
      end
      step_end();
    end

    // Queue fills with LE low; one pop frees exactly one credit.
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    n_hs = 0;
    for (int i = 0; i < 8; i++) begin
      step_begin(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      if (Imem_Req) n_hs++;
      step_end();
    end
    check("full_handshakes", n_hs, 4);
    step_begin(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    check("full_req_low", Imem_Req, 1'b0);
    step_end();
    n_hs = 0;
    for (int i = 0; i < 6; i++) begin
      step_begin(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      if (Imem_Req) n_hs++;
      step_end();
    end
    check("pop_one_more_req", n_hs, 1);

    // Reset with the queue full.
    step_begin(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check("prerst_valid", Inst_Valid, 1'b1);
    step_end();
    step_begin(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    check("rst_valid", Inst_Valid, 1'b0);
    check("rst_addr", Imem_Addr, RstPc);
    check("rst_instr", Instruction_OUT, 32'h0000_0013);
    check("rst_req", Imem_Req, 1'b1);
    step_end();

    // Two slow requests in flight, then redirect to an unaligned target.
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    lat_min = 5; lat_max = 5;
    cycle(1'b0, 1'b1, 32'h200, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 32'h403, 1'b0, 1'b1);
    lat_min = 1; lat_max = 1;
    step_begin(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    check("redir_addr", Imem_Addr, 32'h400);
    step_end();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step_begin(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      if (Inst_Valid === 1'b1) begin
        found = 1'b1;
        check("redir_first_pc", PCOG_OUT, 32'h400);
        check("redir_first_instr", Instruction_OUT, mem_word(32'h400));
      end
      step_end();
    end
    check("redir_valid_seen", found, 1'b1);

    // Redirect coinciding with a response and an issue handshake.
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step_begin(1'b0, 1'b1, 32'h800, 1'b1, 1'b1);
    check("coinc_req", Imem_Req, 1'b1);
    check("coinc_rvalid_driven", Imem_Rvalid, 1'b1);
    step_end();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step_begin(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
      if (Inst_Valid === 1'b1) begin
        found = 1'b1;
        check("coinc_first_pc", PCOG_OUT, 32'h800);
        check("coinc_first_instr", Instruction_OUT, mem_word(32'h800));
      end
      step_end();
    end
    check("coinc_valid_seen", found, 1'b1);

`ifdef IFU_PERF_CNT_EN
    // Five starved cycles with LE high.
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    step_begin(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check("stall_five", Fetch_Stall_Count, 32'd5);
    step_end();
`endif

    // Randomized traffic, including wrap-around targets and occasional reset.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      logic        r_le, r_redir, r_rdy, r_rst;
      logic [31:0] r_ta;
      r_le    = ($urandom % 10) < 7;
      r_redir = ($urandom % 20) == 0;
      r_ta    = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : $urandom;
      r_rdy   = ($urandom % 10) < 7;
      r_rst   = ($urandom % 300) != 0;
      cycle(r_le, r_redir, r_ta, r_rdy, r_rst);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
